store_bus_writer: RTL and testbench
===================================

# store_bus_writer

Store-side counterpart of the load data unit. It accepts one store per request from the MEM stage, lane-aligns the store data, and generates byte enables for SB/SH/SW. It splits any store that crosses a 32-bit word boundary into two word-aligned beats on the data-memory write bus using a valid/ready handshake. It sits between the MEM-stage store path and the data-memory write port.

## Interface
- DATA_WIDTH, 32, store data and bus data width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- st_valid  in  1  store request present.
- st_ready  out  1  block can accept a request; high only in IDLE.
- MEM_Funct3  in  3  store type: 000 SB, 001 SH, 010 SW; all other codes are illegal.
- st_addr  in  ADDR_WIDTH  byte address.
- st_wdata  in  DATA_WIDTH  register data; SB uses [7:0], SH uses [15:0].
- st_done  out  1  one-cycle pulse when the store completes.
- st_err  out  1  valid only with st_done; 1 means illegal funct3 and no bus write.
- st_split  out  1  valid only with st_done; 1 means the store used two beats.
- bus_valid  out  1  write beat valid.
- bus_ready  in  1  memory accepts the beat.
- bus_addr  out  ADDR_WIDTH  word-aligned address; [1:0] is always 00.
- bus_wdata  out  DATA_WIDTH  lane-aligned write data.
- bus_be  out  4  byte enables; bit i enables bits [8i+7:8i].

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- **IDLE**
  - On st_valid && st_ready, capture MEM_Funct3, st_addr and st_wdata.
  - Illegal funct3: go to RESP with st_err=1. No bus activity occurs.
  - Legal funct3: compute both beats and go to BEAT0.
- **Beat computation**
  - Size n = 1/2/4 bytes; offset o = st_addr[1:0].
  - 64-bit shifted data d64 = zero-extended data << (8*o).
  - be8 = ((1<<n)-1) << o.
  - Beat0: addr {st_addr[31:2],00}, wdata d64[31:0], be be8[3:0].
  - Beat1 is required iff be8[7:4] != 0.
    - Its addr is beat0 addr + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
    - Its wdata is d64[63:32] and its be is be8[7:4].
  - Unused bytes of bus_wdata are 0.
- **BEAT0**
  - Hold bus_valid=1 with beat0 fields.
  - On bus_valid && bus_ready: go to BEAT1 if a split is required, otherwise go to RESP.
- **BEAT1**
  - Hold bus_valid=1 with beat1 fields.
  - On handshake, go to RESP.
- **RESP**
  - st_done=1 for exactly one cycle.
  - st_err and st_split are valid in this cycle and 0 otherwise.
  - Next state is IDLE.
- Handshake rules:
  - While bus_valid=1 and bus_ready=0, bus_addr, bus_wdata and bus_be stay stable.
  - bus_valid never deasserts without a handshake, except on reset.
- Only one store is in flight at a time; no buffering.
- Inputs are ignored outside IDLE.
- bus_ready is ignored when bus_valid=0.

## Timing
- Reset values: state IDLE, st_ready=1, st_done=0, st_err=0, st_split=0, bus_valid=0, bus_addr=0, bus_wdata=0, bus_be=0.
- Reset asserted mid-operation aborts immediately to IDLE and bus_valid drops asynchronously. A beat already accepted is not retried.
- All bus outputs and st_done/st_err/st_split are registered. st_ready is decoded from state.
- Accept at edge N with bus_ready held high:
  - Aligned store: bus_valid high in cycle N+1, handshake at the end of N+1, st_done in N+2, st_ready=1 in N+3.
  - Split store: beat0 in N+1, beat1 in N+2, st_done in N+3, st_ready=1 in N+4.
  - Illegal funct3: st_done with st_err=1 in N+1, st_ready=1 in N+2.
- Each cycle of bus_ready=0 during a beat adds one cycle of latency.
- Minimum issue interval is 3 cycles (aligned) or 4 cycles (split).

## Test plan
- SB, addr 0x00001003, data 0x000000AB -> one beat:
  - addr 0x00001000, wdata 0xAB000000, be 1000.
  - st_done with st_split=0, st_err=0.
- SH, addr 0x00002002, data 0x00001234 -> one beat: addr 0x00002000, wdata 0x12340000, be 1100.
- SW, addr 0x00003001, data 0xAABBCCDD -> two beats, st_split=1:
  - Beat0: addr 0x00003000, wdata 0xBBCCDD00, be 1110.
  - Beat1: addr 0x00003004, wdata 0x000000AA, be 0001.
- SH, addr 0xFFFFFFFF, data 0x0000BEEF, with bus_ready low for 3 cycles on each beat:
  - Beat0: addr 0xFFFFFFFC, wdata 0xEF000000, be 1000, held stable while stalled.
  - Beat1: addr 0x00000000, wdata 0x000000BE, be 0001.
  - st_done exactly once.
- MEM_Funct3=011 -> no bus_valid, st_done with st_err=1 one cycle after accept. Then accept a SW at 0x10 aligned normally.
- Split SW in progress; drop rst_n during BEAT1 -> bus_valid=0 and st_ready=1 immediately, no st_done. After rst_n rises, a new SB completes normally.

Source files
------------

// File: rtl/store_bus_writer.sv
// Store path to the data-memory write port: lane-aligns SB/SH/SW data, builds byte
// enables, and splits word-crossing stores into two word-aligned valid/ready beats.
module store_bus_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [2:0]            MEM_Funct3,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic                  st_done,
    output logic                  st_err,
    output logic                  st_split,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_be
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   beat1_addr_reg;
    logic [DATA_WIDTH-1:0]   beat1_wdata_reg;
    logic [3:0]              beat1_be_reg;
    logic                    split_reg;

    logic                    legal;
    logic [3:0]              size_mask;
    logic [DATA_WIDTH-1:0]   data_sel;
    logic [2*DATA_WIDTH-1:0] d64;
    logic [7:0]              be8;
    logic [ADDR_WIDTH-1:0]   beat0_addr;
    logic [ADDR_WIDTH-1:0]   beat1_addr;

    // Size decode; data is zero-extended so unused lanes are driven to 0.
    always_comb begin
        legal     = 1'b1;
        size_mask = 4'b0000;
        data_sel  = '0;
        case (MEM_Funct3)
            3'b000: begin
                size_mask = 4'b0001;
                data_sel  = {24'b0, st_wdata[7:0]};
            end
            3'b001: begin
                size_mask = 4'b0011;
                data_sel  = {16'b0, st_wdata[15:0]};
            end
            3'b010: begin
                size_mask = 4'b1111;
                data_sel  = st_wdata;
            end
            default: legal = 1'b0;
        endcase
    end

    assign d64        = {{DATA_WIDTH{1'b0}}, data_sel} << {st_addr[1:0], 3'b000};
    assign be8        = {4'b0000, size_mask} << st_addr[1:0];
    assign beat0_addr = {st_addr[ADDR_WIDTH-1:2], 2'b00};
    // Upper-word address wraps naturally at the top of the address space.
    assign beat1_addr = beat0_addr + ADDR_WIDTH'(4);

    assign st_ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            beat1_addr_reg  <= '0;
            beat1_wdata_reg <= '0;
            beat1_be_reg    <= '0;
            split_reg       <= 1'b0;
            st_done         <= 1'b0;
            st_err          <= 1'b0;
            st_split        <= 1'b0;
            bus_valid       <= 1'b0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
            bus_be          <= '0;
        end else begin
            st_done  <= 1'b0;
            st_err   <= 1'b0;
            st_split <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (st_valid) begin
                        if (!legal) begin
                            state_reg <= RESP;
                            st_done   <= 1'b1;
                            st_err    <= 1'b1;
                        end else begin
                            state_reg       <= BEAT0;
                            bus_valid       <= 1'b1;
                            bus_addr        <= beat0_addr;
                            bus_wdata       <= d64[DATA_WIDTH-1:0];
                            bus_be          <= be8[3:0];
                            beat1_addr_reg  <= beat1_addr;
                            beat1_wdata_reg <= d64[2*DATA_WIDTH-1:DATA_WIDTH];
                            beat1_be_reg    <= be8[7:4];
                            split_reg       <= |be8[7:4];
                        end
                    end
                end
                BEAT0: begin
                    if (bus_ready) begin
                        if (split_reg) begin
                            state_reg <= BEAT1;
                            bus_addr  <= beat1_addr_reg;
                            bus_wdata <= beat1_wdata_reg;
                            bus_be    <= beat1_be_reg;
                        end else begin
                            state_reg <= RESP;
                            bus_valid <= 1'b0;
                            bus_addr  <= '0;
                            bus_wdata <= '0;
                            bus_be    <= '0;
                            st_done   <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ready) begin
                        state_reg <= RESP;
                        bus_valid <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_be    <= '0;
                        st_done   <= 1'b1;
                        st_split  <= 1'b1;
                    end
                end
                RESP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_bus_writer.sv
// Randomized bench for store_bus_writer: a byte-by-byte store model predicts bus beats,
// completion flags and latency; one negedge process compares every cycle.
module tb_store_bus_writer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    typedef struct packed {
        logic err;
        logic split;
        int   nbeats;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [2:0]  MEM_Funct3 = 3'b000;
    logic [31:0] st_addr = '0;
    logic [31:0] st_wdata = '0;
    logic        st_done;
    logic        st_err;
    logic        st_split;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;

    beat_t beat_q[$];
    done_t done_q[$];
    bit    inflight = 1'b0;
    int    lat = 0;
    int    stalls = 0;
    int    ready_mode = 0;

    store_bus_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .MEM_Funct3(MEM_Funct3), .st_addr(st_addr), .st_wdata(st_wdata),
        .st_done(st_done), .st_err(st_err), .st_split(st_split),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Places each stored byte in its own word/lane; beats fall out of the word grouping.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, output int nb,
                                  output beat_t b0, output beat_t b1);
        int n;
        logic [31:0] base, ba, word;
        int lane;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        b0 = '0;
        b1 = '0;
        nb = 0;
        base = a & 32'hFFFF_FFFC;
        for (int k = 0; k < n; k++) begin
            ba   = a + 32'(k);
            word = ba & 32'hFFFF_FFFC;
            lane = int'(ba[1:0]);
            if (word == base) begin
                b0.addr = word;
                b0.wdata[8*lane +: 8] = d[8*k +: 8];
                b0.be[lane] = 1'b1;
                if (nb < 1) nb = 1;
            end else begin
                b1.addr = word;
                b1.wdata[8*lane +: 8] = d[8*k +: 8];
                b1.be[lane] = 1'b1;
                nb = 2;
            end
        end
    endfunction

    // Memory-side ready: always, random, or three stall cycles at the start of each beat.
    always @(posedge clk) begin
        static int low_cnt = 0;
        #1;
        case (ready_mode)
            0: bus_ready = 1'b1;
            1: bus_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bus_valid) begin
                    if (low_cnt < 3) begin
                        bus_ready = 1'b0;
                        low_cnt++;
                    end else begin
                        bus_ready = 1'b1;
                        low_cnt = 0;
                    end
                end else begin
                    bus_ready = 1'b0;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        beat_t e;
        done_t dd;
        int exp_lat;
        if (!rst_n) begin
            chk(st_ready && !bus_valid && !st_done && !st_err && !st_split &&
                bus_addr == 0 && bus_wdata == 0 && bus_be == 0, "reset_values",
                {st_ready, bus_valid, st_done, st_err, st_split, bus_addr, bus_wdata, bus_be},
                {1'b1, 91'b0});
        end else begin
            chk(st_ready == !inflight, "st_ready", 96'(st_ready), 96'(!inflight));
            if (inflight) lat++;
            if (bus_valid) begin
                if (beat_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {bus_addr, bus_wdata, 28'b0, bus_be}, 96'b0);
                end else begin
                    e = beat_q[0];
                    chk(bus_addr == e.addr && bus_wdata == e.wdata && bus_be == e.be, "beat",
                        {bus_addr, bus_wdata, 28'b0, bus_be}, {e.addr, e.wdata, 28'b0, e.be});
                    if (bus_ready) void'(beat_q.pop_front());
                    else stalls++;
                end
            end
            if (st_done) begin
                if (done_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", {st_err, st_split}, 96'b0);
                end else begin
                    dd = done_q.pop_front();
                    exp_lat = dd.err ? 1 : dd.nbeats + stalls + 1;
                    chk(st_err == dd.err && st_split == dd.split && beat_q.size() == 0,
                        "done_flags", {st_err, st_split, 32'(beat_q.size())},
                        {dd.err, dd.split, 32'd0});
                    chk(lat == exp_lat, "done_latency", 96'(lat), 96'(exp_lat));
                    inflight = 1'b0;
                end
            end else begin
                chk(!st_err && !st_split, "flags_idle", {st_err, st_split}, 96'b0);
            end
        end
    end

    task automatic push_expect(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int nb;
        beat_t b0, b1;
        done_t dd;
        model(f3, a, d, nb, b0, b1);
        if (nb >= 1) beat_q.push_back(b0);
        if (nb == 2) beat_q.push_back(b1);
        dd.err = (nb == 0);
        dd.split = (nb == 2);
        dd.nbeats = nb;
        done_q.push_back(dd);
        lat = 0;
        stalls = 0;
        inflight = 1'b1;
    endtask

    // Presents one request, returns right after the accepting edge with expectations queued.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int k;
        @(posedge clk);
        #1;
        st_valid = 1'b1;
        MEM_Funct3 = f3;
        st_addr = a;
        st_wdata = d;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (st_ready) break;
        end
        chk(k < 50, "accept_timeout", 96'(k), 96'd0);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        MEM_Funct3 = 3'($urandom);
        st_addr = $urandom;
        st_wdata = $urandom;
        push_expect(f3, a, d);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int k;
        issue(f3, a, d);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (!inflight) break;
        end
        chk(!inflight, "done_timeout", 96'(k), 96'd0);
        if (inflight) begin
            beat_q.delete();
            done_q.delete();
            inflight = 1'b0;
        end
    endtask

    initial begin
        int nb;
        beat_t b0, b1;
        int r;
        logic [2:0] f3;
        logic [31:0] a;

        model(3'd0, 32'h0000_1003, 32'h0000_00AB, nb, b0, b1);
        chk(nb == 1 && b0 == {32'h0000_1000, 32'hAB00_0000, 4'b1000}, "model_sb",
            {32'(nb), b0[67:4], 28'b0}, {32'd1, 32'h0000_1000, 32'hAB00_0000, 28'b0});
        model(3'd1, 32'h0000_2002, 32'h0000_1234, nb, b0, b1);
        chk(nb == 1 && b0 == {32'h0000_2000, 32'h1234_0000, 4'b1100}, "model_sh",
            {32'(nb), b0[67:4], 28'b0}, {32'd1, 32'h0000_2000, 32'h1234_0000, 28'b0});
        model(3'd2, 32'h0000_3001, 32'hAABB_CCDD, nb, b0, b1);
        chk(nb == 2 && b0 == {32'h0000_3000, 32'hBBCC_DD00, 4'b1110} &&
            b1 == {32'h0000_3004, 32'h0000_00AA, 4'b0001}, "model_sw_split",
            {32'(nb), b1[67:4], 28'b0}, {32'd2, 32'h0000_3004, 32'h0000_00AA, 28'b0});
        model(3'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, nb, b0, b1);
        chk(nb == 2 && b0 == {32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000} &&
            b1 == {32'h0000_0000, 32'h0000_00BE, 4'b0001}, "model_wrap",
            {32'(nb), b1[67:4], 28'b0}, {32'd2, 32'h0, 32'h0000_00BE, 28'b0});
        model(3'd3, 32'h0000_0010, 32'h1, nb, b0, b1);
        chk(nb == 0, "model_illegal", 96'(nb), 96'd0);

        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        ready_mode = 0;
        do_store(3'd0, 32'h0000_1003, 32'h0000_00AB);
        do_store(3'd1, 32'h0000_2002, 32'h0000_1234);
        do_store(3'd2, 32'h0000_3001, 32'hAABB_CCDD);
        ready_mode = 2;
        do_store(3'd1, 32'hFFFF_FFFF, 32'h0000_BEEF);
        ready_mode = 0;
        do_store(3'd3, 32'h0000_0040, 32'h1234_5678);
        do_store(3'd2, 32'h0000_0010, 32'h0BAD_F00D);

        // Reset while the upper beat of a split word is on the bus.
        issue(3'd2, 32'h0000_5002, 32'h1122_3344);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(!bus_valid && st_ready, "async_abort", {bus_valid, st_ready}, {1'b0, 1'b1});
        beat_q.delete();
        done_q.delete();
        inflight = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_store(3'd0, 32'h0000_6001, 32'h0000_005A);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            ready_mode = $urandom_range(0, 2);
            do_store(f3, a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
